// File: rtl/key_debounce_pulser_if.sv
// Key conditioner signal bundle: raw key and repeat control in, debounced level and pulses out.
interface key_debounce_pulser_if;
    logic       key_n;
    logic       repeat_en;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       step_pulse;
    logic [2:0] state_dbg;

    // Drives the raw key and observes the conditioned outputs.
    modport master (
        output key_n,
        output repeat_en,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  step_pulse,
        input  state_dbg
    );

    // The conditioner itself.
    modport slave (
        input  key_n,
        input  repeat_en,
        output key_level,
        output press_pulse,
        output release_pulse,
        output step_pulse,
        output state_dbg
    );
endinterface

// File: rtl/key_debounce_pulser.sv
// Pushbutton conditioner: synchronises an active-low raw key, debounces press and
// release, and produces one-cycle press/release/step pulses with optional auto-repeat.
module key_debounce_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter int unsigned CNT_WIDTH       = 25
) (
    input logic                  clock,
    input logic                  reset,
    key_debounce_pulser_if.slave kp
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESS_CHK   = 3'd1,
        HELD        = 3'd2,
        REPEAT      = 3'd3,
        RELEASE_CHK = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]           sync;
    logic                 key_s;
    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic                 level_q, level_next;
    logic                 press_q, press_next;
    logic                 release_q, release_next;
    logic                 step_q, step_next;

    // Two-flop synchroniser for the raw key, preset to the released level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], kp.key_n};
        end
    end

    assign key_s = ~sync[1];

    // State, shared counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            level_q   <= level_next;
            press_q   <= press_next;
            release_q <= release_next;
            step_q    <= step_next;
        end
    end

    // Next-state, counter and pulse decode; pulses default low so each lasts one cycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = level_q;
        press_next   = 1'b0;
        release_next = 1'b0;
        step_next    = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_s) begin
                    state_next = PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                    step_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end else if (kp.repeat_en && cnt == HLD_LAST) begin
                    state_next = REPEAT;
                    cnt_next   = '0;
                    step_next  = 1'b1;
                end else if (kp.repeat_en) begin
                    cnt_next = cnt + CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            REPEAT: begin
                if (!key_s) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end else if (!kp.repeat_en) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == RPT_LAST) begin
                    cnt_next  = '0;
                    step_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                // A release bounce returns to HELD, so the hold timer starts over.
                if (key_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign kp.key_level     = level_q;
    assign kp.press_pulse   = press_q;
    assign kp.release_pulse = release_q;
    assign kp.step_pulse    = step_q;
    assign kp.state_dbg     = state;

endmodule

// File: tb/tb_key_debounce_pulser.sv
// Directed bench for key_debounce_pulser with short debounce/hold/repeat periods.
module tb_key_debounce_pulser;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    int   press_cnt;
    int   rel_cnt;
    int   step_cnt;
    int   level_cnt;

    key_debounce_pulser_if kif ();

    key_debounce_pulser #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3),
        .CNT_WIDTH      (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp   (kif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        press_cnt = 0;
        rel_cnt   = 0;
        step_cnt  = 0;
        level_cnt = 0;
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (kif.press_pulse === 1'b1)   press_cnt++;
            if (kif.release_pulse === 1'b1) rel_cnt++;
            if (kif.step_pulse === 1'b1)    step_cnt++;
            if (kif.key_level === 1'b1)     level_cnt++;
            check("press_and_release", 32'(kif.press_pulse & kif.release_pulse), 0);
            check("release_and_step", 32'(kif.release_pulse & kif.step_pulse), 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_counts();
        reset         = 1'b0;
        kif.key_n     = 1'b0;
        kif.repeat_en = 1'b0;

        // 1: reset with key held, then press accepted on the 7th edge
        tick(3);
        check("rst_level", 32'(kif.key_level), 0);
        check("rst_press", 32'(kif.press_pulse), 0);
        check("rst_release", 32'(kif.release_pulse), 0);
        check("rst_step", 32'(kif.step_pulse), 0);
        check("rst_state", 32'(kif.state_dbg), 0);
        check("rst_no_press", 32'(press_cnt), 0);
        reset = 1'b1;
        tick(6);
        check("t1_press_early", 32'(press_cnt), 0);
        check("t1_level_early", 32'(kif.key_level), 0);
        tick(1);
        check("t1_press", 32'(kif.press_pulse), 1);
        check("t1_step", 32'(kif.step_pulse), 1);
        check("t1_level", 32'(kif.key_level), 1);
        check("t1_state", 32'(kif.state_dbg), 2);
        tick(1);
        check("t1_press_one_cycle", 32'(kif.press_pulse), 0);
        check("t1_level_hold", 32'(kif.key_level), 1);
        check("t1_press_count", 32'(press_cnt), 1);
        check("t1_step_count", 32'(step_cnt), 1);
        kif.key_n = 1'b1;
        tick(6);
        check("t1_rel_early", 32'(rel_cnt), 0);
        tick(1);
        check("t1_release", 32'(kif.release_pulse), 1);
        check("t1_rel_level", 32'(kif.key_level), 0);
        check("t1_rel_state", 32'(kif.state_dbg), 0);

        // 2: bounce, low 2 / high 1 four times
        tick(2);
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            kif.key_n = 1'b0;
            tick(2);
            kif.key_n = 1'b1;
            tick(1);
        end
        tick(10);
        check("t2_press", 32'(press_cnt), 0);
        check("t2_step", 32'(step_cnt), 0);
        check("t2_release", 32'(rel_cnt), 0);
        check("t2_level", 32'(level_cnt), 0);
        check("t2_state", 32'(kif.state_dbg), 0);

        // 3a: clean 6-cycle press then release
        clear_counts();
        kif.key_n = 1'b0;
        tick(6);
        kif.key_n = 1'b1;
        tick(1);
        check("t3_press", 32'(kif.press_pulse), 1);
        tick(5);
        check("t3_rel_early", 32'(rel_cnt), 0);
        tick(1);
        check("t3_release", 32'(kif.release_pulse), 1);
        check("t3_level_low", 32'(kif.key_level), 0);
        check("t3_level_cycles", 32'(level_cnt), 6);
        check("t3_press_count", 32'(press_cnt), 1);

        // 3b: 2-cycle release glitch mid-hold
        tick(2);
        clear_counts();
        kif.key_n = 1'b0;
        tick(8);
        check("t3b_press_count", 32'(press_cnt), 1);
        kif.key_n = 1'b1;
        tick(2);
        kif.key_n = 1'b0;
        tick(10);
        check("t3b_no_release", 32'(rel_cnt), 0);
        check("t3b_level", 32'(kif.key_level), 1);
        check("t3b_state", 32'(kif.state_dbg), 2);
        kif.key_n = 1'b1;
        tick(6);
        check("t3b_rel_early", 32'(rel_cnt), 0);
        tick(1);
        check("t3b_release", 32'(kif.release_pulse), 1);
        check("t3b_rel_count", 32'(rel_cnt), 1);

        // 4: auto-repeat while held 30 cycles after the press
        tick(2);
        clear_counts();
        kif.repeat_en = 1'b1;
        kif.key_n     = 1'b0;
        tick(7);
        check("t4_press", 32'(kif.press_pulse), 1);
        check("t4_first_step", 32'(step_cnt), 1);
        tick(9);
        check("t4_hold_quiet", 32'(step_cnt), 1);
        tick(1);
        check("t4_hold_step", 32'(kif.step_pulse), 1);
        check("t4_repeat_state", 32'(kif.state_dbg), 3);
        tick(2);
        check("t4_rpt_gap", 32'(kif.step_pulse), 0);
        tick(1);
        check("t4_rpt_step", 32'(kif.step_pulse), 1);
        tick(17);
        check("t4_step_total", 32'(step_cnt), 8);
        check("t4_press_total", 32'(press_cnt), 1);
        check("t4_state", 32'(kif.state_dbg), 3);

        // 5: drop repeat_en in REPEAT, then raise it again
        kif.repeat_en = 1'b0;
        tick(1);
        check("t5_stop_step", 32'(kif.step_pulse), 0);
        check("t5_stop_state", 32'(kif.state_dbg), 2);
        tick(5);
        check("t5_no_steps", 32'(step_cnt), 8);
        kif.repeat_en = 1'b1;
        tick(9);
        check("t5_resume_quiet", 32'(step_cnt), 8);
        tick(1);
        check("t5_resume_step", 32'(kif.step_pulse), 1);
        check("t5_resume_state", 32'(kif.state_dbg), 3);

        // 6: asynchronous reset mid-REPEAT with key still held
        reset = 1'b0;
        #1;
        check("t6_async_state", 32'(kif.state_dbg), 0);
        check("t6_async_level", 32'(kif.key_level), 0);
        check("t6_async_step", 32'(kif.step_pulse), 0);
        check("t6_async_press", 32'(kif.press_pulse), 0);
        tick(1);
        reset = 1'b1;
        clear_counts();
        tick(6);
        check("t6_press_early", 32'(press_cnt), 0);
        check("t6_level_early", 32'(kif.key_level), 0);
        tick(1);
        check("t6_press", 32'(kif.press_pulse), 1);
        check("t6_level", 32'(kif.key_level), 1);

        kif.key_n = 1'b1;
        tick(8);
        check("t6_final_release", 32'(rel_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_debounce_pulser.md
Name: key_debounce_pulser

Overview:
Conditions a raw active-low pushbutton into clean, single-cycle step pulses for the downstream T-flip-flop counter stage, which then runs on a free-running system clock with a step enable instead of clocking directly off the key. The block synchronises the raw key, debounces press and release, and emits one-cycle press, release and step pulses. It also provides an optional hold-to-auto-repeat function. The debounced level and pulses drive the counter's enable and LED indicators.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a press or release (20 ms at 50 MHz); must be at least 1.
HOLD_CYCLES, 25000000, cycles a debounced press must be held before auto-repeat starts; must be at least 1.
REPEAT_CYCLES, 5000000, period between auto-repeat pulses; must be at least 1.
CNT_WIDTH, 25, width of the shared cycle counter; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)-1.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset.
key_n  input  1  raw pushbutton, 0 = pressed; asynchronous to clock and bouncy.
repeat_en  input  1  1 = auto-repeat allowed while held; sampled synchronously.
key_level  output  1  debounced key state, 1 = pressed.
press_pulse  output  1  one-cycle pulse on each accepted press.
release_pulse  output  1  one-cycle pulse on each accepted release.
step_pulse  output  1  one-cycle pulse on each press_pulse and each auto-repeat event.
state_dbg  output  3  current FSM state encoding, for LED display.

Behaviour:
- Reset (reset=0, asynchronous):
  - 2-flop synchroniser preset to 1 (released).
  - FSM set to IDLE; counter cleared to 0.
  - All outputs 0; state_dbg reads IDLE.
  - Reset takes effect mid-press with no pulse emitted.
- Synchroniser: key_s = ~sync[1]. key_s reflects key_n after 2 clock edges. Only key_s is used downstream.
- All outputs are registered. Pulses are high for exactly one cycle.
- State encodings: IDLE=0, PRESS_CHK=1, HELD=2, REPEAT=3, RELEASE_CHK=4.
- IDLE:
  - key_s=1 -> PRESS_CHK, cnt=0.
- PRESS_CHK:
  - key_s=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
  - Else if cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, key_level<=1, press_pulse=step_pulse=1.
  - Else cnt++.
- HELD:
  - key_s=0 -> RELEASE_CHK, cnt=0.
  - Else if repeat_en=1 and cnt==HOLD_CYCLES-1 -> REPEAT, cnt=0, step_pulse=1.
  - Else if repeat_en=1, cnt++ (saturating at HOLD_CYCLES-1).
  - Else (repeat_en=0) cnt=0.
- REPEAT:
  - key_s=0 -> RELEASE_CHK, cnt=0.
  - Else if repeat_en=0 -> HELD, cnt=0, no pulse.
  - Else if cnt==REPEAT_CYCLES-1 -> step_pulse=1, cnt=0.
  - Else cnt++.
- RELEASE_CHK:
  - key_s=1 -> HELD, cnt=0 (release bounce rejected; the hold timer restarts).
  - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0, key_level<=0, release_pulse=1.
  - Else cnt++.
- Press latency: with key_n held low from the first clock edge that samples it low (edge 1), press_pulse is high in the cycle following edge DEBOUNCE_CYCLES+3. Release latency is identical.
- Never asserted simultaneously:
  - press_pulse and release_pulse.
  - release_pulse and step_pulse.
- Between a press_pulse and the next release_pulse, key_level is continuously 1.
- Counter: unsigned, CNT_WIDTH bits. Compares use == against parameter-1, so there is no wrap-around.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3):
1. Reset asserted with key_n=0 -> all outputs 0, state_dbg=0; after reset release with key_n held 0 -> exactly one press_pulse and step_pulse, 7 edges after the first low sample; key_level=1 thereafter.
2. Bounce: key_n toggles low 2 cycles / high 1 cycle, four times, then stays high -> no pulses, key_level stays 0, FSM returns to IDLE.
3. Clean press of 6 cycles, then release -> one press_pulse, one release_pulse (7 edges after release), key_level high for 6 cycles total; a release glitch of 2 cycles mid-hold yields no release_pulse.
4. repeat_en=1, key held 30 cycles after press_pulse -> step_pulse at press, then 10 cycles later, then every 3 cycles: 1+1+6 = 8 step_pulses, 1 press_pulse.
5. repeat_en dropped in REPEAT -> step_pulses stop immediately; re-raising it gives the next step_pulse 10 cycles later.
6. reset pulsed low mid-REPEAT for 1 cycle -> outputs 0 asynchronously; with the key still held, a new press_pulse follows after 7 edges.
